// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row, col}; row 3 carries the E,0,F,D layout of the pad.
    localparam logic [0:15][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_decode.sv
// Combinational (row, column) to hex value lookup.
module keypad_decode
    import keypad_scanner_pkg::*;
(
    input  logic [1:0] row_i,
    input  logic [1:0] col_i,
    output logic [3:0] hex_o
);

    assign hex_o = KEY_MAP[{row_i, col_i}];

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller with press/release debounce and a
// two-digit history of accepted keys.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int CNT_MAX = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cols_q, cols_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       dnew_q, dnew_d;
    logic [3:0]       dold_q, dold_d;
    logic [3:0]       dec_hex;
    logic             latched_low;

    keypad_decode u_decode (
        .row_i (row_q),
        .col_i (col_q),
        .hex_o (dec_hex)
    );

    // Only the latched row matters once a key has been captured.
    assign latched_low = ~sync2_q[row_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cols_d      = cols_q;
        row_d       = row_q;
        col_d       = col_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        dnew_d      = dnew_q;
        dold_d      = dold_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (sync2_q != 4'hF) begin
                        row_d   = lowest_low(sync2_q);
                        col_d   = lowest_low(cols_q);
                        state_d = DEBOUNCE;
                    end else begin
                        cols_d = {cols_q[2:0], cols_q[3]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!latched_low) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    key_valid_d = 1'b1;
                    key_d       = dec_hex;
                    dold_d      = dnew_q;
                    dnew_d      = dec_hex;
                    state_d     = HELD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!latched_low) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (latched_low) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    cols_d  = {cols_q[2:0], cols_q[3]};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            state_q     <= SCAN;
            cnt_q       <= '0;
            cols_q      <= COL_RESET;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            dnew_q      <= 4'h0;
            dold_q      <= 4'h0;
        end else begin
            sync1_q     <= rows;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            dnew_q      <= dnew_d;
            dold_q      <= dold_d;
        end
    end

    assign cols      = cols_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign digit_new = dnew_q;
    assign digit_old = dold_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: table of single presses plus hand-written corner cases.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic [3:0]  digit_new;
    logic [3:0]  digit_old;
    logic [15:0] pressed;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] exp_key;
    } vec_t;

    typedef struct {
        logic [3:0] key;
        logic [3:0] dnew;
        logic [3:0] dold;
    } sb_t;

    vec_t       vecs[7];
    sb_t        sb_q[$];
    logic [3:0] model_new = 4'h0;
    logic [3:0] model_old = 4'h0;
    logic [11:0] prev_out = 12'h000;

    keypad_scanner #(
        .SCAN_DIV  (4),
        .DB_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void expect_press(logic [3:0] k);
        sb_t e;
        e.key  = k;
        e.dnew = k;
        e.dold = model_new;
        sb_q.push_back(e);
        model_old = model_new;
        model_new = k;
    endfunction

    always @(negedge clk) begin
        if (reset && key_valid) begin
            sb_t e;
            pulses++;
            if (sb_q.size() == 0) begin
                chk("unexpected_key_valid", {28'd0, key}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("kv_key", {28'd0, key}, {28'd0, e.key});
                chk("kv_digit_new", {28'd0, digit_new}, {28'd0, e.dnew});
                chk("kv_digit_old", {28'd0, digit_old}, {28'd0, e.dold});
                $display("key_valid key=%h digit_new=%h digit_old=%h", key, digit_new, digit_old);
            end
        end else if (reset) begin
            chk("outputs_stable", {20'd0, key, digit_new, digit_old}, {20'd0, prev_out});
        end
        prev_out = {key, digit_new, digit_old};
    end

    task automatic wait_pulse(int target, int budget, string name);
        int n = 0;
        while (pulses < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, (pulses >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_cols(logic [3:0] target, int budget, string name);
        int n = 0;
        while (cols != target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {28'd0, cols}, {28'd0, target});
    endtask

    initial begin
        logic [3:0] c_exp;
        int base;
        int n;

        vecs[0] = '{1, 1, 4'h5};
        vecs[1] = '{0, 3, 4'hA};
        vecs[2] = '{0, 0, 4'h1};
        vecs[3] = '{3, 0, 4'hE};
        vecs[4] = '{3, 3, 4'hD};
        vecs[5] = '{1, 2, 4'h6};
        vecs[6] = '{2, 3, 4'hC};

        pressed = '0;
        reset   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_cols", {28'd0, cols}, 32'hE);
        chk("rst_key", {28'd0, key}, 32'h0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'h0);
        chk("rst_digit_new", {28'd0, digit_new}, 32'h0);
        chk("rst_digit_old", {28'd0, digit_old}, 32'h0);

        c_exp = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            c_exp = {c_exp[2:0], c_exp[3]};
            chk("scan_rotate", {28'd0, cols}, {28'd0, c_exp});
        end

        for (int i = 0; i < 7; i++) begin
            base = pulses;
            expect_press(vecs[i].exp_key);
            pressed[vecs[i].row*4 + vecs[i].col] = 1'b1;
            wait_pulse(base + 1, 120, "press_timeout");
            repeat (150) @(posedge clk);
            #1;
            pressed = '0;
            repeat (40) @(posedge clk);
            #1;
            chk("single_pulse", pulses, base + 1);
            chk("digit_new_after", {28'd0, digit_new}, {28'd0, model_new});
            chk("digit_old_after", {28'd0, digit_old}, {28'd0, model_old});
            $display("press row=%0d col=%0d key=%h pulses=%0d", vecs[i].row, vecs[i].col, key, pulses - base);
        end

        // Short glitch on '9' must not be accepted and scanning must continue.
        base = pulses;
        pressed[2*4+2] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        pressed = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_no_pulse", pulses, base);
        chk("glitch_digit_new", {28'd0, digit_new}, {28'd0, model_new});
        c_exp = cols;
        n = 0;
        while (cols == c_exp && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        c_exp = cols;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_scan_resumes", {28'd0, cols}, {28'd0, c_exp[2:0], c_exp[3]});
        $display("glitch key=9 pulses=%0d", pulses - base);

        // '4' and '7' together: lowest row wins; '7' alone is ignored until release completes.
        base = pulses;
        expect_press(4'h4);
        pressed[1*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        wait_pulse(base + 1, 120, "dual_timeout");
        repeat (30) @(posedge clk);
        #1;
        pressed[1*4+0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("dual_hold7_no_pulse", pulses, base + 1);
        pressed = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("dual_total_pulses", pulses, base + 1);
        $display("dual press keys=4,7 pulses=%0d key=%h", pulses - base, key);

        // Reset in the middle of debouncing 'F'.
        base = pulses;
        wait_cols(4'b0111, 20, "f_wait_col3");
        pressed[3*4+2] = 1'b1;
        wait_cols(4'b1011, 20, "f_wait_col2");
        repeat (14) @(posedge clk);
        #1;
        chk("f_col_held", {28'd0, cols}, 32'hB);
        chk("f_no_pulse_yet", pulses, base);
        reset = 1'b0;
        #1;
        chk("f_rst_cols", {28'd0, cols}, 32'hE);
        chk("f_rst_key", {28'd0, key}, 32'h0);
        chk("f_rst_key_valid", {31'd0, key_valid}, 32'h0);
        chk("f_rst_digit_new", {28'd0, digit_new}, 32'h0);
        chk("f_rst_digit_old", {28'd0, digit_old}, 32'h0);
        model_new = 4'h0;
        model_old = 4'h0;
        pressed   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("f_no_pulse", pulses, base);
        $display("reset mid-debounce key=F pulses=%0d", pulses - base);

        // Bouncy release of '0', then clean release.
        base = pulses;
        expect_press(4'h0);
        pressed[3*4+1] = 1'b1;
        wait_pulse(base + 1, 120, "zero_timeout");
        repeat (30) @(posedge clk);
        #1;
        pressed[3*4+1] = 1'b0; repeat (2) @(posedge clk); #1;
        pressed[3*4+1] = 1'b1; repeat (1) @(posedge clk); #1;
        pressed[3*4+1] = 1'b0; repeat (1) @(posedge clk); #1;
        pressed[3*4+1] = 1'b1; repeat (1) @(posedge clk); #1;
        pressed[3*4+1] = 1'b0;
        chk("zero_col_held", {28'd0, cols}, 32'hD);
        n = 0;
        while (cols == 4'b1101 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("zero_rotate_after_release", {28'd0, cols}, 32'hB);
        chk("zero_release_time", (n >= 16 && n <= 24) ? 32'd1 : 32'd0, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("zero_single_pulse", pulses, base + 1);
        $display("bouncy release key=0 pulses=%0d release_cycles=%0d", pulses - base, n);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001: Parameter SCAN_DIV, default 1000, sets the clock cycles each column is driven during scanning.
REQ-002: Parameter DB_CYCLES, default 50000, sets the clock cycles of stable level required for press and release debounce.
REQ-003: Port clk, input, 1 bit, is the single system clock; all state is updated on its rising edge.
REQ-004: Port reset, input, 1 bit, is the asynchronous active-low reset (0 = in reset).
REQ-005: Port rows, input, 4 bits, carries keypad row sense lines; they are active-low, pulled up externally, and asynchronous to clk.
REQ-006: Port cols, output, 4 bits, carries keypad column drives; they are active-low, with exactly one bit low at all times.
REQ-007: Port key, output, 4 bits, holds the hex value of the last accepted key.
REQ-008: Port key_valid, output, 1 bit, pulses high for one cycle per accepted key press.
REQ-009: Port digit_new, output, 4 bits, holds the most recent accepted key and feeds the display's s1.
REQ-010: Port digit_old, output, 4 bits, holds the previous accepted key and feeds the display's s0.

Function
REQ-011: Each rows bit SHALL pass through a 2-flop synchronizer; all decisions use only the synchronized rows.
REQ-012: The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013: In SCAN, the dwell counter SHALL count 0..SCAN_DIV-1; on the terminal count the drive SHALL rotate 1110→1101→1011→0111→1110.
REQ-014: In SCAN, on the terminal count with synchronized rows ≠ 4'hF, the FSM SHALL latch the current column index and the lowest-index low row, SHALL NOT rotate the column, and SHALL enter DEBOUNCE.
REQ-015: In DEBOUNCE, the column SHALL be held and the counter SHALL increment each cycle while the latched row stays low.
- If the latched row goes high before the count completes: return to SCAN, no output change.
REQ-016: When the DEBOUNCE count reaches DB_CYCLES, i.e. DB_CYCLES clocks after DEBOUNCE entry, the following SHALL happen in one cycle, and the FSM SHALL enter HELD:
- key_valid = 1.
- key ← decoded value.
- digit_old ← digit_new.
- digit_new ← decoded value.
REQ-017: In HELD, the column SHALL stay held; when the latched row goes high the FSM SHALL enter RELEASE with the counter cleared.
REQ-018: In RELEASE, DB_CYCLES consecutive cycles of the latched row high SHALL return the FSM to SCAN, with the counter cleared and the column rotated.
- Any low sample on the latched row SHALL return the FSM to HELD.
- This path SHALL NOT pulse key_valid.
REQ-019: Rows other than the latched row, and all other columns, SHALL be ignored from DEBOUNCE entry until the return to SCAN; each physical press yields at most one key_valid.
REQ-020: Decode (row,col) SHALL use this map:
- r0: 1,2,3,A
- r1: 4,5,6,B
- r2: 7,8,9,C
- r3: E,0,F,D
REQ-021: key, digit_new and digit_old SHALL change only in the key_valid cycle.

Reset
REQ-022: While reset=0, outputs SHALL asynchronously be:
- cols = 4'b1110
- key = 0
- key_valid = 0
- digit_new = 0
- digit_old = 0
REQ-023: While reset=0, internal state SHALL asynchronously be:
- state = SCAN
- counters = 0
- synchronizer flops = 1
REQ-024: Reset asserted in any state, including mid-DEBOUNCE, SHALL discard the pending key with no key_valid pulse.

Structure
REQ-025: A shared package SHALL hold the state enum, the keypad map constant table, and the column rotation reset constant 4'b1110.
REQ-026: Row/column-to-hex mapping SHALL be a separate combinational sub-module named keypad_decode; synchronizer, counters and FSM stay in keypad_scanner.

Verification
All scenarios use SCAN_DIV=4 and DB_CYCLES=16; the keypad model drives rows low only when its column is driven.
REQ-027: Reset for 3 cycles, then release -> cols=1110, key=0, digit_new=0, digit_old=0, key_valid=0, and cols rotate every 4 cycles.
REQ-028: Hold '5' (r1,c1) for 200 cycles -> exactly one key_valid, key=5, digit_new=5, digit_old=0; then press 'A' (r0,c3) -> digit_new=A, digit_old=5.
REQ-029: Pulse '9' low for 8 cycles only -> no key_valid, digits unchanged, scanning resumes.
REQ-030: Press '4' and '7' together (c0; r1 and r2) -> single key_valid with key=4; holding '7' after releasing '4' yields no pulse until full release.
REQ-031: Release '0' with a 5-cycle bounce, then release cleanly -> no second key_valid; after 16 high cycles, cols rotates.
REQ-032: Assert reset 10 cycles into DEBOUNCE of 'F' -> no key_valid; outputs at reset values immediately, without waiting for a clock edge.
